// File: rtl/pcpi_nibble_issuer_if.sv
// Bus bundle for pcpi_nibble_issuer: nibble handshake, PCPI issue port and result readback.
interface pcpi_nibble_issuer_if;
  logic        nib_req;
  logic [3:0]  nib_data;
  logic        nib_ack;
  logic [2:0]  nib_count;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        busy;
  logic        res_valid;
  logic        res_wr;
  logic [1:0]  res_sel;
  logic [7:0]  res_byte;
  logic        err;

  // Host / PCPI-unit side.
  modport master (
    output nib_req, nib_data, pcpi_ready, pcpi_wr, pcpi_rd, pcpi_wait, res_sel,
    input  nib_ack, nib_count, pcpi_valid, pcpi_insn, busy, res_valid, res_wr, res_byte, err
  );

  // Issuer side.
  modport slave (
    input  nib_req, nib_data, pcpi_ready, pcpi_wr, pcpi_rd, pcpi_wait, res_sel,
    output nib_ack, nib_count, pcpi_valid, pcpi_insn, busy, res_valid, res_wr, res_byte, err
  );
endinterface

// File: rtl/pcpi_nibble_issuer.sv
// Assembles a 32-bit instruction from eight req/ack nibbles, issues it over PCPI
// valid/ready, and exposes the latched result one byte at a time.
// Optional macro PCPI_TIMEOUT_EN builds a 16-bit issue watchdog that drives err.
module pcpi_nibble_issuer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pcpi_nibble_issuer_if.slave      bus_if
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic                   ack_q, ack_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [31:0]            insn_q, insn_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   res_valid_q, res_valid_d;
  logic                   res_wr_q, res_wr_d;
  logic [31:0]            result_q, result_d;
  logic                   sreq;
  logic                   accept;

`ifdef PCPI_TIMEOUT_EN
  logic [15:0]            wdog_q, wdog_d;
  logic                   err_q, err_d;
`else
  logic                   unused_timeout;
`endif

  assign sreq = sync_q[SYNC_STAGES-1];

  // Next-state and output logic for the collect/issue/done sequencer.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], bus_if.nib_req};
    state_d     = state_q;
    ack_d       = ack_q;
    cnt_d       = cnt_q;
    insn_d      = insn_q;
    valid_d     = valid_q;
    res_valid_d = res_valid_q;
    res_wr_d    = res_wr_q;
    result_d    = result_q;
`ifdef PCPI_TIMEOUT_EN
    wdog_d      = wdog_q;
    err_d       = err_q;
`endif

    accept = sreq && !ack_q && ((state_q == S_COLLECT) || (state_q == S_DONE));

    // Ack drops as soon as the synchronised request is seen low, in any state.
    if (!sreq) begin
      ack_d = 1'b0;
    end

    if (accept) begin
      ack_d                         = 1'b1;
      insn_d[{cnt_q, 2'b00} +: 4]   = bus_if.nib_data;
      cnt_d                         = cnt_q + 3'd1;
    end

    case (state_q)
      S_COLLECT: begin
        if (accept && (cnt_q == 3'd7)) begin
          state_d = S_ISSUE;
          valid_d = 1'b1;
`ifdef PCPI_TIMEOUT_EN
          wdog_d  = 16'd0;
`endif
        end
      end
      S_ISSUE: begin
        if (bus_if.pcpi_ready) begin
          state_d     = S_DONE;
          valid_d     = 1'b0;
          res_valid_d = 1'b1;
          res_wr_d    = bus_if.pcpi_wr;
          if (bus_if.pcpi_wr) begin
            result_d = bus_if.pcpi_rd;
          end
        end
`ifdef PCPI_TIMEOUT_EN
        else if (bus_if.pcpi_wait) begin
          wdog_d = 16'd0;
        end else if (wdog_q == 16'(TIMEOUT_CYCLES - 1)) begin
          wdog_d      = wdog_q + 16'd1;
          state_d     = S_DONE;
          valid_d     = 1'b0;
          res_valid_d = 1'b1;
          res_wr_d    = 1'b0;
          err_d       = 1'b1;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      S_DONE: begin
        if (accept) begin
          state_d     = S_COLLECT;
          res_valid_d = 1'b0;
          res_wr_d    = 1'b0;
`ifdef PCPI_TIMEOUT_EN
          err_d       = 1'b0;
`endif
        end
      end
      default: begin
        state_d = S_COLLECT;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d == S_ISSUE);
  end

  // State and registered outputs; async reset discards any partial instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= S_COLLECT;
      ack_q       <= 1'b0;
      cnt_q       <= 3'd0;
      insn_q      <= 32'd0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_wr_q    <= 1'b0;
      result_q    <= 32'd0;
`ifdef PCPI_TIMEOUT_EN
      wdog_q      <= 16'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      ack_q       <= ack_d;
      cnt_q       <= cnt_d;
      insn_q      <= insn_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_wr_q    <= res_wr_d;
      result_q    <= result_d;
`ifdef PCPI_TIMEOUT_EN
      wdog_q      <= wdog_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus_if.nib_ack    = ack_q;
  assign bus_if.nib_count  = cnt_q;
  assign bus_if.pcpi_valid = valid_q;
  assign bus_if.pcpi_insn  = insn_q;
  assign bus_if.busy       = busy_q;
  assign bus_if.res_valid  = res_valid_q;
  assign bus_if.res_wr     = res_wr_q;
  assign bus_if.res_byte   = result_q[{bus_if.res_sel, 3'b000} +: 8];

`ifdef PCPI_TIMEOUT_EN
  assign bus_if.err = err_q;
`else
  // Without the watchdog, pcpi_wait and the limit have no effect.
  assign bus_if.err     = 1'b0;
  assign unused_timeout = bus_if.pcpi_wait ^ (^16'(TIMEOUT_CYCLES));
`endif

endmodule
